// File: rtl/uart_mmio_ctrl.sv
// uart_mmio_ctrl: memory-mapped 8N1 UART with TXD/RXD/CON registers and an integer baud divider.
// Optional build macro UART_IRQ_EN adds the irq output and the CON[5] irq_en bit.
`timescale 1ns/1ps
module uart_mmio_ctrl #(
  parameter int          CLK_FREQ = 100_000_000,
  parameter int          BAUD     = 9600,
  parameter logic [31:0] ADDR_TXD = 32'h4000_0018,
  parameter logic [31:0] ADDR_RXD = 32'h4000_001C,
  parameter logic [31:0] ADDR_CON = 32'h4000_0020
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        mem_read,
  input  logic        mem_write,
  output logic [31:0] rdata,
  output logic        hit,
  input  logic        uart_rx,
  output logic        uart_tx
`ifdef UART_IRQ_EN
  ,
  output logic        irq
`endif
);

  localparam int DIV   = CLK_FREQ / BAUD;
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(DIV / 2 - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} uart_state_t;

  logic sel_txd, sel_rxd, sel_con;
  logic txd_store, rxd_load, con_load;
  logic [31:0] con_val;

  uart_state_t      tx_state, tx_state_nxt;
  logic [CNT_W-1:0] tx_cnt;
  logic [2:0]       tx_bit;
  logic [7:0]       tx_data;
  logic             tx_tick, tx_start, tx_end, tx_busy, tx_done;

  logic             rx_s1, rx_s2, rx_prev, rx_fall;
  uart_state_t      rx_state, rx_state_nxt;
  logic [CNT_W-1:0] rx_cnt;
  logic [2:0]       rx_bit;
  logic [7:0]       rx_shift, rxd_data;
  logic             rx_tick, rx_half, rx_shift_en, rx_stop_ok, rx_stop_bad;
  logic             rx_ready, rx_overrun, frame_err;

  logic unused_wdata;
  assign unused_wdata = ^wdata[31:8];

  assign sel_txd   = (addr == ADDR_TXD);
  assign sel_rxd   = (addr == ADDR_RXD);
  assign sel_con   = (addr == ADDR_CON);
  assign hit       = sel_txd | sel_rxd | sel_con;
  assign txd_store = mem_write & sel_txd;
  assign rxd_load  = mem_read & sel_rxd;
  assign con_load  = mem_read & sel_con;

`ifdef UART_IRQ_EN
  logic con_store, irq_en;
  assign con_store = mem_write & sel_con;
`endif

  // Assemble the control/status word
  always_comb begin
    con_val    = '0;
    con_val[0] = tx_busy;
    con_val[1] = rx_ready;
    con_val[2] = tx_done;
    con_val[3] = rx_overrun;
    con_val[4] = frame_err;
`ifdef UART_IRQ_EN
    con_val[5] = irq_en;
`endif
  end

  // Load data mux; zero unless a register is hit by a load
  always_comb begin
    rdata = '0;
    if (mem_read) begin
      if (sel_txd)      rdata = {24'h0, tx_data};
      else if (sel_rxd) rdata = {24'h0, rxd_data};
      else if (sel_con) rdata = con_val;
    end
  end

  assign tx_tick  = (tx_cnt == BIT_LAST);
  assign tx_start = txd_store & (tx_state == ST_IDLE);
  assign tx_end   = (tx_state == ST_STOP) & tx_tick;

  // TX state register with its baud counter and bit index
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_state <= ST_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
    end else begin
      tx_state <= tx_state_nxt;
      if (tx_state == ST_IDLE || tx_tick) tx_cnt <= '0;
      else                                tx_cnt <= tx_cnt + 1'b1;
      if (tx_state == ST_IDLE)                 tx_bit <= '0;
      else if (tx_state == ST_DATA && tx_tick) tx_bit <= tx_bit + 3'd1;
    end
  end

  // TX next-state: each frame bit lasts exactly one full baud period
  always_comb begin
    tx_state_nxt = tx_state;
    case (tx_state)
      ST_IDLE:  if (tx_start) tx_state_nxt = ST_START;
      ST_START: if (tx_tick) tx_state_nxt = ST_DATA;
      ST_DATA:  if (tx_tick && tx_bit == 3'd7) tx_state_nxt = ST_STOP;
      ST_STOP:  if (tx_tick) tx_state_nxt = ST_IDLE;
      default:  tx_state_nxt = ST_IDLE;
    endcase
  end

  // TX outputs decoded from state so reset drives the line high at once
  always_comb begin
    tx_busy = (tx_state != ST_IDLE);
    case (tx_state)
      ST_START: uart_tx = 1'b0;
      ST_DATA:  uart_tx = tx_data[tx_bit];
      default:  uart_tx = 1'b1;
    endcase
  end

  // TXD holding register; stores while busy are dropped
  always_ff @(posedge clk or posedge reset) begin
    if (reset)         tx_data <= '0;
    else if (tx_start) tx_data <= wdata[7:0];
  end

  // Two-flop synchronizer plus one delayed copy for falling-edge detection
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= uart_rx;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  assign rx_fall = rx_prev & ~rx_s2;
  assign rx_tick = (rx_cnt == BIT_LAST);
  assign rx_half = (rx_cnt == HALF_LAST);

  // RX state register; the half-period START wait aligns later samples to bit centres
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_state <= ST_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
    end else begin
      rx_state <= rx_state_nxt;
      case (rx_state)
        ST_IDLE:  rx_cnt <= '0;
        ST_START: rx_cnt <= rx_half ? '0 : rx_cnt + 1'b1;
        default:  rx_cnt <= rx_tick ? '0 : rx_cnt + 1'b1;
      endcase
      if (rx_state != ST_DATA) rx_bit <= '0;
      else if (rx_tick)        rx_bit <= rx_bit + 3'd1;
    end
  end

  // RX next-state: a start bit that is high again at mid-bit is a glitch
  always_comb begin
    rx_state_nxt = rx_state;
    case (rx_state)
      ST_IDLE:  if (rx_fall) rx_state_nxt = ST_START;
      ST_START: if (rx_half) rx_state_nxt = rx_s2 ? ST_IDLE : ST_DATA;
      ST_DATA:  if (rx_tick && rx_bit == 3'd7) rx_state_nxt = ST_STOP;
      ST_STOP:  if (rx_tick) rx_state_nxt = ST_IDLE;
      default:  rx_state_nxt = ST_IDLE;
    endcase
  end

  // RX outputs: data-bit shift enable and stop-bit verdict
  always_comb begin
    rx_shift_en = 1'b0;
    rx_stop_ok  = 1'b0;
    rx_stop_bad = 1'b0;
    case (rx_state)
      ST_DATA: rx_shift_en = rx_tick;
      ST_STOP: begin
        rx_stop_ok  = rx_tick & rx_s2;
        rx_stop_bad = rx_tick & ~rx_s2;
      end
      default: ;
    endcase
  end

  // RX shift register, LSB arrives first
  always_ff @(posedge clk) begin
    if (rx_shift_en) rx_shift <= {rx_s2, rx_shift[7:1]};
  end

  // Status and RXD: new events take priority over clear-on-read
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rxd_data   <= '0;
      rx_ready   <= 1'b0;
      tx_done    <= 1'b0;
      rx_overrun <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      if (rx_stop_ok) rxd_data <= rx_shift;
      if (rx_stop_ok)    rx_ready <= 1'b1;
      else if (rxd_load) rx_ready <= 1'b0;
      if (tx_end)        tx_done <= 1'b1;
      else if (con_load) tx_done <= 1'b0;
      if (rx_stop_ok && rx_ready && !rxd_load) rx_overrun <= 1'b1;
      else if (con_load)                       rx_overrun <= 1'b0;
      if (rx_stop_bad)   frame_err <= 1'b1;
      else if (con_load) frame_err <= 1'b0;
    end
  end

`ifdef UART_IRQ_EN
  // Interrupt enable bit and registered interrupt request
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_en <= 1'b0;
      irq    <= 1'b0;
    end else begin
      if (con_store) irq_en <= wdata[5];
      irq <= irq_en & (rx_ready | tx_done);
    end
  end
`endif

endmodule
